// File: rtl/sync_debounce_edge_detect.sv
// sync_debounce_edge_detect: debounces an already-synchronised input and
// produces a debounced level, one-cycle rise/fall pulses and saturating
// rise/fall event counters.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds glitch_count[7:0],
// which counts qualification episodes that were aborted.
module sync_debounce_edge_detect #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_in,
    input  logic             clr_count,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] fall_count
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_count
`endif
);

    localparam int unsigned QW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [QW-1:0] CNT_LAST = QW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_t;

    state_t          r_state;
    logic [QW-1:0]   r_cnt;

    // Qualification FSM with registered level, pulse and busy outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_STABLE_LO;
            r_cnt      <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (r_state)
                ST_STABLE_LO: begin
                    if (sync_in) begin
                        r_state <= ST_WAIT_HI;
                        r_cnt   <= QW'(1);
                        busy    <= 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    if (!sync_in) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= ST_STABLE_HI;
                        r_cnt      <= '0;
                        busy       <= 1'b0;
                        level_out  <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + QW'(1);
                    end
                end
                ST_STABLE_HI: begin
                    if (!sync_in) begin
                        r_state <= ST_WAIT_LO;
                        r_cnt   <= QW'(1);
                        busy    <= 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (sync_in) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= ST_STABLE_LO;
                        r_cnt      <= '0;
                        busy       <= 1'b0;
                        level_out  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + QW'(1);
                    end
                end
                default: begin
                    r_state <= ST_STABLE_LO;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Event counters advance while the matching pulse is high; clr_count
    // in that same cycle leaves the pulsed counter at 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_count <= '0;
            fall_count <= '0;
        end else if (clr_count) begin
            rise_count <= rise_pulse ? CNT_W'(1) : '0;
            fall_count <= fall_pulse ? CNT_W'(1) : '0;
        end else begin
            if (rise_pulse && (rise_count != '1)) begin
                rise_count <= rise_count + CNT_W'(1);
            end
            if (fall_pulse && (fall_count != '1)) begin
                fall_count <= fall_count + CNT_W'(1);
            end
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic w_abort;
    logic r_abort;

    // A WAIT state falling back to its stable state is an aborted episode
    always_comb begin
        w_abort = 1'b0;
        if ((r_state == ST_WAIT_HI) && !sync_in) begin
            w_abort = 1'b1;
        end
        if ((r_state == ST_WAIT_LO) && sync_in) begin
            w_abort = 1'b1;
        end
    end

    // Glitch counter, timed like the event counters (one-cycle abort flag)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_abort      <= 1'b0;
            glitch_count <= '0;
        end else begin
            r_abort <= w_abort;
            if (clr_count) begin
                glitch_count <= r_abort ? 8'd1 : 8'd0;
            end else if (r_abort && (glitch_count != 8'hFF)) begin
                glitch_count <= glitch_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_debounce_edge_detect.sv
// Testbench for sync_debounce_edge_detect: directed scenarios plus random
// bounce patterns, checked every cycle against a run-length reference model.
module tb_sync_debounce_edge_detect;

    localparam int unsigned D = 4;

    logic        clk;
    logic        reset_n;
    logic        sync_in;
    logic        clr_count;

    logic        level_a, rise_a, fall_a, busy_a;
    logic [15:0] rc_a, fc_a;
    logic        level_b, rise_b, fall_b, busy_b;
    logic [1:0]  rc_b, fc_b;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]  gc_a, gc_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sync_debounce_edge_detect #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .sync_in(sync_in), .clr_count(clr_count),
        .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .busy(busy_a),
        .rise_count(rc_a), .fall_count(fc_a)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_count(gc_a)
`endif
    );

    sync_debounce_edge_detect #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .sync_in(sync_in), .clr_count(clr_count),
        .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .busy(busy_b),
        .rise_count(rc_b), .fall_count(fc_b)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_count(gc_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: level plus length of the current run of samples that
    // disagree with it; counters follow the expected pulses one cycle later
    logic m_level, m_rise, m_fall, m_abort;
    int   m_streak, m_rc16, m_fc16, m_rc2, m_fc2, m_gc;

    function automatic int cnt_next(input int cur, input logic evt, input logic clr, input int maxv);
        if (clr) return evt ? 1 : 0;
        if (evt && (cur < maxv)) return cur + 1;
        return cur;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int   streak_n;
        logic lvl_n;
        logic r_n, f_n, ab_n;
        if (!reset_n) begin
            m_level  <= 1'b0;
            m_rise   <= 1'b0;
            m_fall   <= 1'b0;
            m_abort  <= 1'b0;
            m_streak <= 0;
            m_rc16   <= 0;
            m_fc16   <= 0;
            m_rc2    <= 0;
            m_fc2    <= 0;
            m_gc     <= 0;
        end else begin
            lvl_n    = m_level;
            streak_n = 0;
            r_n      = 1'b0;
            f_n      = 1'b0;
            ab_n     = 1'b0;
            if (sync_in != m_level) begin
                streak_n = m_streak + 1;
                if (streak_n == int'(D)) begin
                    lvl_n    = ~m_level;
                    r_n      = lvl_n;
                    f_n      = ~lvl_n;
                    streak_n = 0;
                end
            end else begin
                ab_n = (m_streak > 0);
            end
            m_level  <= lvl_n;
            m_streak <= streak_n;
            m_rise   <= r_n;
            m_fall   <= f_n;
            m_abort  <= ab_n;
            m_rc16   <= cnt_next(m_rc16, m_rise, clr_count, 65535);
            m_fc16   <= cnt_next(m_fc16, m_fall, clr_count, 65535);
            m_rc2    <= cnt_next(m_rc2, m_rise, clr_count, 3);
            m_fc2    <= cnt_next(m_fc2, m_fall, clr_count, 3);
            m_gc     <= cnt_next(m_gc, m_abort, clr_count, 255);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic exp_busy;
        exp_busy = (m_streak > 0);
        check("level_a", 32'(level_a), 32'(m_level));
        check("rise_a",  32'(rise_a),  32'(m_rise));
        check("fall_a",  32'(fall_a),  32'(m_fall));
        check("busy_a",  32'(busy_a),  32'(exp_busy));
        check("rc_a",    32'(rc_a),    32'(m_rc16));
        check("fc_a",    32'(fc_a),    32'(m_fc16));
        check("level_b", 32'(level_b), 32'(m_level));
        check("busy_b",  32'(busy_b),  32'(exp_busy));
        check("rc_b",    32'(rc_b),    32'(m_rc2));
        check("fc_b",    32'(fc_b),    32'(m_fc2));
        check("pulse_excl", 32'(rise_a & fall_a), 32'(0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("gc_a", 32'(gc_a), 32'(m_gc));
        check("gc_b", 32'(gc_b), 32'(m_gc));
`endif
    endtask

    // Drive one cycle of input, then compare outputs on the following negedge
    task automatic tick(input logic s, input logic c);
        sync_in   = s;
        clr_count = c;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int run;
        logic s;
        sync_in   = 1'b1;
        clr_count = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level_a), 32'(0));
        check("rst_busy",  32'(busy_a),  32'(0));
        check_all();
        reset_n = 1'b1;

        // sync_in held high through reset: level rises on the 4th edge
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b0);
            check("post_rst_level", 32'(level_a), (i >= 4) ? 32'(1) : 32'(0));
        end
        // Fall, then a clean rise, then a 3-cycle glitch
        repeat (10) tick(1'b0, 1'b0);
        repeat (10) tick(1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0);
        repeat (3)  tick(1'b1, 1'b0);
        repeat (6)  tick(1'b0, 1'b0);
        check("glitch_level", 32'(level_a), 32'(0));
        // Five accepted rises saturate the narrow counter
        repeat (5) begin
            repeat (6) tick(1'b1, 1'b0);
            repeat (6) tick(1'b0, 1'b0);
        end
        check("sat_rc_b", 32'(rc_b), 32'(3));
        // clr_count coincident with a rise pulse
        tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, m_rise);
        check("clr_coinc_rc", 32'(rc_a), 32'(1));
        check("clr_coinc_fc", 32'(fc_a), 32'(0));
        // Reset asserted while qualifying a fall, cnt = 2
        repeat (2) tick(1'b0, 1'b0);
        check("midwait_busy", 32'(busy_a), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        check("midrst_level", 32'(level_a), 32'(0));
        check("midrst_busy",  32'(busy_a),  32'(0));
        check("midrst_rc",    32'(rc_a),    32'(0));
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        sync_in = 1'b0;
        // Toggling every cycle never moves the level
        for (int i = 0; i < 12; i++) tick(1'(i % 2), 1'b0);
        check("toggle_level", 32'(level_a), 32'(0));
        // Random runs of mixed length with occasional clears
        s = 1'b0;
        for (int k = 0; k < 600; k++) begin
            s   = ~s;
            run = int'($urandom_range(1, 7));
            for (int j = 0; j < run; j++) begin
                tick(s, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
